// File: rtl/apu_pkg.sv
// apu_pkg: shared APU register offsets, frame-reset delays and frame-control FSM states
package apu_pkg;

    localparam logic [4:0] APU_ADDR_STATUS  = 5'h15;
    localparam logic [4:0] APU_ADDR_FRAME   = 5'h17;
    localparam logic [2:0] FRAME_DELAY_EVEN = 3'd4;
    localparam logic [2:0] FRAME_DELAY_ODD  = 3'd3;

    typedef enum logic [1:0] {IDLE, DELAY, APPLY} frame_state_e;

    // Counter preload: the DELAY state spans D cycles, counting D-1 down to zero.
    function automatic logic [1:0] frame_delay_m1(input logic odd);
        logic [2:0] m;
        m = (odd ? FRAME_DELAY_ODD : FRAME_DELAY_EVEN) - 3'd1;
        return m[1:0];
    endfunction

endpackage

// File: rtl/apu_frame_ctrl.sv
// apu_frame_ctrl: $4017 frame-counter write with delayed restart, $4015 status read and IRQ clear.
// Define APU_FRAME_RESET_JITTER_EN to make the restart delay depend on apu_cycle (3 or 4), else fixed 3.
module apu_frame_ctrl
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reg_wr,
    input  logic       reg_rd,
    input  logic [4:0] reg_addr,
    input  logic [7:0] reg_wdata,
    input  logic       apu_cycle,
    input  logic       frame_irq,
    input  logic       dmc_irq,
    input  logic       dmc_active,
    input  logic [3:0] len_nz,
    output logic       mode,
    output logic       noint,
    output logic       update,
    output logic       clrint,
    output logic [7:0] status_rdata,
    output logic       cpu_irq
);

    frame_state_e state, state_nx;
    logic [1:0]   cnt, cnt_nx;
    logic         pending;
    logic         wr_frame, rd_status, odd;
    logic [5:0]   unused_wdata;

    assign wr_frame     = reg_wr && reg_addr == APU_ADDR_FRAME;
    assign rd_status    = reg_rd && reg_addr == APU_ADDR_STATUS;
    assign unused_wdata = reg_wdata[5:0];

`ifdef APU_FRAME_RESET_JITTER_EN
    assign odd = apu_cycle;
`else
    logic unused_apu_cycle;
    assign unused_apu_cycle = apu_cycle;
    assign odd = 1'b1;
`endif

    // A new write always restarts the delay, discarding whatever was in flight.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (wr_frame) begin
            state_nx = DELAY;
            cnt_nx   = frame_delay_m1(odd);
        end else if (state == DELAY) begin
            state_nx = cnt == 2'd0 ? APPLY : DELAY;
            cnt_nx   = cnt == 2'd0 ? cnt : cnt - 2'd1;
        end else if (state == APPLY) begin
            state_nx = IDLE;
        end
    end

    // Reset parks the FSM mid-delay so that release behaves like a write of 8'h00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DELAY;
            cnt     <= frame_delay_m1(1'b1);
            pending <= 1'b0;
            mode    <= 1'b0;
            noint   <= 1'b0;
            clrint  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            clrint <= rd_status;
            if (wr_frame) begin
                pending <= reg_wdata[7];
                noint   <= reg_wdata[6];
            end
            if (state_nx == APPLY)
                mode <= pending;
        end
    end

    assign update       = state == APPLY;
    assign status_rdata = {dmc_irq, frame_irq, 1'b0, dmc_active, len_nz};
    assign cpu_irq      = frame_irq | dmc_irq;

endmodule

// File: tb/tb_apu_frame_ctrl.sv
// tb_apu_frame_ctrl: directed and randomized checks of apu_frame_ctrl against a timestamp model
module tb_apu_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       reg_wr = 1'b0, reg_rd = 1'b0;
    logic [4:0] reg_addr = 5'd0;
    logic [7:0] reg_wdata = 8'd0;
    logic       apu_cycle = 1'b0, frame_irq = 1'b0, dmc_irq = 1'b0, dmc_active = 1'b0;
    logic [3:0] len_nz = 4'd0;
    logic       mode, noint, update, clrint, cpu_irq;
    logic [7:0] status_rdata;

    int tests = 0;
    int fails = 0;

    // Model: edge index, edge at which the next update is due, latched values.
    int   e = 0;
    int   due = 3;
    logic pend = 1'b0, mode_m = 1'b0, noint_m = 1'b0;

    apu_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .apu_cycle(apu_cycle), .frame_irq(frame_irq), .dmc_irq(dmc_irq),
        .dmc_active(dmc_active), .len_nz(len_nz), .mode(mode), .noint(noint), .update(update),
        .clrint(clrint), .status_rdata(status_rdata), .cpu_irq(cpu_irq)
    );

    always #5 clk = ~clk;

    function automatic int dly(input logic ac);
`ifdef APU_FRAME_RESET_JITTER_EN
        return ac ? 3 : 4;
`else
        return 3;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    task automatic step(input logic wr, input logic rd, input logic [4:0] addr, input logic [7:0] wd,
                        input logic ac, input logic fi, input logic di, input logic da,
                        input logic [3:0] ln);
        @(negedge clk);
        reg_wr = wr; reg_rd = rd; reg_addr = addr; reg_wdata = wd;
        apu_cycle = ac; frame_irq = fi; dmc_irq = di; dmc_active = da; len_nz = ln;
        #1;
        chk("status_rdata", status_rdata, {di, fi, 1'b0, da, ln});
        chk("cpu_irq", 8'(cpu_irq), 8'(fi | di));
        @(posedge clk);
        e++;
        if (wr && addr == 5'h17) begin
            due = e + dly(ac);
            pend = wd[7];
            noint_m = wd[6];
        end
        if (due == e) mode_m = pend;
        #1;
        chk("update", 8'(update), 8'(due == e));
        chk("mode", 8'(mode), 8'(mode_m));
        chk("noint", 8'(noint), 8'(noint_m));
        chk("clrint", 8'(clrint), 8'(rd && addr == 5'h15));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 5'd0, 8'd0, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic wr17(input logic [7:0] wd, input logic ac, input logic fi);
        step(1, 0, 5'h17, wd, ac, fi, 0, 0, 4'd0);
    endtask

    task automatic do_reset(input int hold);
        #1;
        rst_n = 1'b0;
        reg_wr = 0; reg_rd = 0; reg_addr = 5'd0; reg_wdata = 8'd0;
        #1;
        chk("rst_update", 8'(update), 8'd0);
        chk("rst_mode", 8'(mode), 8'd0);
        chk("rst_noint", 8'(noint), 8'd0);
        chk("rst_clrint", 8'(clrint), 8'd0);
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_hold_update", 8'(update), 8'd0);
        #1;
        rst_n = 1'b1;
        e = 0; due = 3; pend = 0; mode_m = 0; noint_m = 0;
    endtask

    initial begin
        do_reset(2);
        idle(5);                       // automatic restart at cycle 3
        wr17(8'h80, 1, 0); idle(6);    // mode 1, D from apu_cycle=1
        wr17(8'h80, 0, 0); idle(6);    // apu_cycle=0
        wr17(8'h40, 1, 1); idle(6);    // inhibit, mode back to 0
        wr17(8'h80, 0, 0); idle(1);
        wr17(8'h00, 1, 0); idle(6);    // last write wins
        step(0, 1, 5'h15, 8'd0, 0, 1, 0, 0, 4'd0);
        idle(2);
        step(0, 1, 5'h15, 8'd0, 0, 1, 1, 1, 4'b1010);
        step(1, 0, 5'h15, 8'hC0, 1, 0, 0, 0, 4'd0);  // wrong address: ignored
        step(0, 1, 5'h17, 8'd0, 0, 1, 0, 0, 4'd0);
        idle(2);
        wr17(8'hC0, 1, 0); idle(1);
        do_reset(1);                   // abandon pending write
        idle(5);
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [4:0] a;
            r = $urandom_range(0, 3);
            a = r == 0 ? 5'h17 : r == 1 ? 5'h15 : 5'($urandom);
            if ($urandom_range(0, 59) == 0)
                do_reset($urandom_range(1, 2));
            else
                step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, a, 8'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apu_frame_ctrl.md
APU_FRAME_CTRL -- requirements
Module: apu_frame_ctrl

Interface
REQ-001 SHALL have port clk  input  1  CPU-rate clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port reg_wr  input  1  CPU register write strobe, one cycle per access.
REQ-004 SHALL have port reg_rd  input  1  CPU register read strobe, one cycle per access.
REQ-005 SHALL have port reg_addr  input  5  register offset within $4000-$401F.
REQ-006 SHALL have port reg_wdata  input  8  write data.
REQ-007 SHALL have port apu_cycle  input  1  APU half-rate phase from the frame counter.
REQ-008 SHALL have port frame_irq  input  1  frame-counter IRQ flag.
REQ-009 SHALL have ports dmc_irq (1), dmc_active (1) and len_nz (4), all inputs; these are status sources.
REQ-010 SHALL have port mode  output  1  frame sequence select: 0 = 4-step, 1 = 5-step.
REQ-011 SHALL have port noint  output  1  frame IRQ inhibit.
REQ-012 SHALL have port update  output  1  one-cycle frame-counter restart pulse.
REQ-013 SHALL have port clrint  output  1  one-cycle frame IRQ clear pulse.
REQ-014 SHALL have port status_rdata  output  8  $4015 read value.
REQ-015 SHALL have port cpu_irq  output  1  frame_irq | dmc_irq.

Function
REQ-016 SHALL recognise the frame register when reg_wr=1 and reg_addr=5'h17, and the status register when reg_rd=1 and reg_addr=5'h15; all other addresses are ignored.
REQ-017 SHALL register noint <= reg_wdata[6] on the edge that samples a $4017 write; the inhibit takes effect immediately.
REQ-018 SHALL hold reg_wdata[7] in a pending register and start the delay FSM on a $4017 write.
REQ-019 SHALL implement FSM states IDLE, DELAY and APPLY.
  - IDLE -> DELAY on a write.
  - DELAY counts D-1 cycles, then -> APPLY.
  - APPLY lasts one cycle, then -> IDLE.
REQ-020 SHALL set D = 3 if apu_cycle=1 at the write edge, otherwise D = 4 (see REQ-031).
REQ-021 SHALL, in APPLY, drive update=1 and load mode <= pending for exactly one cycle, D cycles after the write edge.
REQ-022 SHALL, on a write during DELAY or APPLY, discard the old pending value, reload D and restart DELAY (last write wins); update SHALL NOT fire for the discarded write.
REQ-023 SHALL drive status_rdata = {dmc_irq, frame_irq, 1'b0, dmc_active, len_nz} combinationally from the inputs.
REQ-024 SHALL pulse clrint for one cycle on the cycle after a $4015 read, so the read returns the flag before it is cleared.
REQ-025 SHALL still honour a $4015 read that coincides with frame_irq rising: clrint fires the next cycle and the frame counter gives clear priority over set.
REQ-026 SHALL handle a simultaneous $4015 read and $4017 write independently; both effects occur.
REQ-027 SHALL drive cpu_irq combinationally as frame_irq | dmc_irq.

Reset
REQ-028 SHALL, while rst_n=0, hold mode=0, noint=0, update=0, clrint=0, pending=0 and the FSM in DELAY with D=3.
REQ-029 SHALL, after rst_n deasserts, perform an automatic restart: update pulses in cycle 3 with mode=0, equivalent to a $4017 write of 8'h00.
REQ-030 SHALL abandon any pending write when reset asserts mid-operation; no update is emitted for it.

Configuration
REQ-031 SHALL implement write-phase jitter under APU_FRAME_RESET_JITTER_EN.
  - Defined: D is 3 or 4 per REQ-020.
  - Undefined: D is fixed at 3 regardless of apu_cycle, and the apu_cycle input is unused.

Structure
REQ-032 SHALL take constants APU_ADDR_STATUS (5'h15), APU_ADDR_FRAME (5'h17), FRAME_DELAY_EVEN (4), FRAME_DELAY_ODD (3) and the FSM state enum from shared package apu_pkg.
REQ-033 SHALL contain no sub-module; it is instantiated beside apu_framecounter in the APU top, driving that block's mode, noint, update and clrint inputs.

Verification
REQ-034 SHALL verify: release rst_n, no writes -> update high exactly in cycle 3, mode=0, noint=0.
REQ-035 SHALL verify: write $4017=8'h80 with apu_cycle=1 -> noint=0 next cycle; update and mode=1 at write+3; with apu_cycle=0 -> at write+4.
REQ-036 SHALL verify: write $4017=8'h40 while frame_irq=1 -> noint=1 on the next cycle; update at write+3/4 with mode=0.
REQ-037 SHALL verify: write 8'h80, then 8'h00 two cycles later -> single update only, D after the second write, mode stays 0.
REQ-038 SHALL verify: frame_irq=1, read $4015 -> status_rdata=8'h40 in the read cycle; clrint high exactly one cycle later.
REQ-039 SHALL verify: assert rst_n low one cycle before a pending update -> no update pulse; after release, the automatic restart occurs in cycle 3.
